// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: free-running h/v counters advanced
// on pix_en, with registered sync, data-enable, coordinates and line/frame/vblank strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT_END  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] H_SYNC_BEG = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] H_SYNC_END = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT_END  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] V_SYNC_BEG = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] V_SYNC_END = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [X_W-1:0]     r_h;
  logic [Y_W-1:0]     r_v;
  logic [FRAME_W-1:0] r_frames;

  logic w_h_last, w_v_last, w_h_zero, w_v_zero;
  logic w_h_act, w_v_act, w_de, w_hs_on, w_vs_on;

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  assign w_h_zero = (r_h == '0);
  assign w_v_zero = (r_v == '0);
  assign w_h_act  = (r_h < H_ACT_END);
  assign w_v_act  = (r_v < V_ACT_END);
  assign w_de     = w_h_act && w_v_act;
  assign w_hs_on  = (r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END);
  assign w_vs_on  = (r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END);

  // r_frames counts wraps of v; it reaches the frame_cnt port one slot later,
  // together with the frame_start of the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_h      <= '0;
      r_v      <= '0;
      r_frames <= '0;
    end else if (pix_en) begin
      if (w_h_last) begin
        r_h <= '0;
        if (w_v_last) begin
          r_v      <= '0;
          r_frames <= r_frames + 1'b1;
        end else begin
          r_v <= r_v + 1'b1;
        end
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  // Outputs register the decode of the pre-edge (h,v), lagging by one slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync        <= ~HS_POL;
      vsync        <= ~VS_POL;
      de           <= 1'b0;
      x            <= '0;
      y            <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_cnt    <= '0;
    end else if (pix_en) begin
      hsync        <= w_hs_on ? HS_POL : ~HS_POL;
      vsync        <= w_vs_on ? VS_POL : ~VS_POL;
      de           <= w_de;
      x            <= w_de ? r_h : '0;
      y            <= w_v_act ? r_v : '0;
      line_start   <= w_h_zero;
      frame_start  <= w_h_zero && w_v_zero;
      vblank_start <= w_h_zero && (r_v == V_ACT_END);
      frame_cnt    <= r_frames;
    end
  end

endmodule
